// File: rtl/sample_clk_pkg.sv
// Shared defaults and helpers for the sample-clock divider.
// Imported by the divider core and its half-period config block.
package sample_clk_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_HALF  = 7;

  // A zero half-period would stall the divider, so it maps to 1.
  function automatic logic [31:0] clamp_half(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/sample_clk_gen_cfg.sv
// Half-period configuration: pending/active registers and load ack.
// New values only take effect on an apply strobe from the core.
module sample_clk_gen_cfg
  import sample_clk_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_half,
  input  logic             i_apply,
  input  logic             i_resync,
  output logic             o_ack,
  output logic [CNT_W-1:0] o_active,
  output logic [CNT_W-1:0] o_next
);

  logic [CNT_W-1:0] r_pend;
  logic             r_pend_v;
  logic [CNT_W-1:0] r_active;
  logic             r_ack;
  logic [CNT_W-1:0] w_clamped;
  logic             w_take_new;
  logic             w_take_pend;

  assign w_clamped   = CNT_W'(clamp_half(32'(i_half)));
  assign w_take_new  = i_apply && i_resync && i_load;
  assign w_take_pend = i_apply && r_pend_v && !w_take_new;

  always_comb begin
    o_next = r_active;
    if (w_take_new)
      o_next = w_clamped;
    else if (w_take_pend)
      o_next = r_pend;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_active <= CNT_W'(DEFAULT_HALF);
      r_ack    <= 1'b0;
    end else begin
      r_ack <= w_take_new || w_take_pend;
      r_active <= o_next;
      if (w_take_new) begin
        r_pend_v <= 1'b0;
      end else if (i_load) begin
        // A load on an apply edge waits for the next apply.
        r_pend   <= w_clamped;
        r_pend_v <= 1'b1;
      end else if (w_take_pend) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  assign o_ack    = r_ack;
  assign o_active = r_active;

endmodule

// File: rtl/sample_clk_gen.sv
// Runtime-tunable sample-clock divider with rise/fall/mid strobes.
// Resync re-phases the output to an external edge.
module sample_clk_gen
  import sample_clk_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             resync,
  input  logic             load,
  input  logic [CNT_W-1:0] half_period_in,
  output logic             load_ack,
  output logic [CNT_W-1:0] active_half,
  output logic             new_clock,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             mid_pulse
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_rise;
  logic             r_fall;
  logic             r_mid;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_active;
  logic [CNT_W-1:0] w_next_half;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_wrap    = enable && (r_cnt == w_active - CNT_W'(1));
  assign w_apply   = resync || !enable || w_wrap;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  sample_clk_gen_cfg #(
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(DEFAULT_HALF)
  ) u_cfg (
    .clock   (clock),
    .reset   (reset),
    .i_load  (load),
    .i_half  (half_period_in),
    .i_apply (w_apply),
    .i_resync(resync),
    .o_ack   (load_ack),
    .o_active(w_active),
    .o_next  (w_next_half)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_mid  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_mid  <= 1'b0;
      if (resync) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_clk  <= !r_clk;
        r_rise <= !r_clk;
        r_fall <= r_clk;
        // Mid strobe uses the half-period that starts on this edge.
        r_mid  <= !r_clk && ((w_next_half >> 1) == '0);
      end else if (enable) begin
        r_cnt <= w_cnt_inc;
        r_mid <= r_clk && (w_cnt_inc == (w_active >> 1));
      end
    end
  end

  assign active_half = w_active;
  assign new_clock   = r_clk;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign mid_pulse   = r_mid;

endmodule

// File: tb/tb_sample_clk_gen.sv
// Directed bench for sample_clk_gen with hand-computed expectations.
// Edges are numbered from reset release or from the last resync.
module tb_sample_clk_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       resync;
  logic       load;
  logic [7:0] half_period_in;
  logic       load_ack;
  logic [7:0] active_half;
  logic       new_clock;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       mid_pulse;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  sample_clk_gen dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .resync        (resync),
    .load          (load),
    .half_period_in(half_period_in),
    .load_ack      (load_ack),
    .active_half   (active_half),
    .new_clock     (new_clock),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .mid_pulse     (mid_pulse)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic c, input logic r,
                         input logic f, input logic m);
    chk({tag, ".clk"}, 32'(new_clock), 32'(c));
    chk({tag, ".rise"}, 32'(rise_pulse), 32'(r));
    chk({tag, ".fall"}, 32'(fall_pulse), 32'(f));
    chk({tag, ".mid"}, 32'(mid_pulse), 32'(m));
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    resync = 1'b0;
    load = 1'b0;
    half_period_in = 8'd0;
    tick(2);
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.active", 32'(active_half), 32'd7);
    chk("rst.ack", 32'(load_ack), 32'd0);
    reset = 1'b0;
    enable = 1'b1;

    // Free-running, default half-period 7
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      chk_out($sformatf("run.e%0d", k),
              (k >= 7 && k < 14) || k >= 21,
              k == 7 || k == 21, k == 14, k == 10);
    end

    // Resync while high, then load 3 at edge 3
    resync = 1'b1;
    tick(1);
    resync = 1'b0;
    chk_out("rs0", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    load = 1'b1;
    half_period_in = 8'd3;
    tick(1);
    load = 1'b0;
    chk("ld3.e3.active", 32'(active_half), 32'd7);
    chk("ld3.e3.ack", 32'(load_ack), 32'd0);
    tick(3);
    chk("ld3.e6.active", 32'(active_half), 32'd7);
    chk("ld3.e6.clk", 32'(new_clock), 32'd0);
    tick(1);
    chk("ld3.e7.active", 32'(active_half), 32'd3);
    chk("ld3.e7.ack", 32'(load_ack), 32'd1);
    chk_out("ld3.e7", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk("ld3.e8.ack", 32'(load_ack), 32'd0);
    chk_out("ld3.e8", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    chk_out("ld3.e9", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_out("ld3.e10", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    chk_out("ld3.e12", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_out("ld3.e13", 1'b1, 1'b1, 1'b0, 1'b0);

    // Load 0 clamps to 1
    load = 1'b1;
    half_period_in = 8'd0;
    tick(1);
    load = 1'b0;
    chk_out("ld0.e14", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    chk_out("ld0.e15", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("ld0.e16.active", 32'(active_half), 32'd1);
    chk("ld0.e16.ack", 32'(load_ack), 32'd1);
    chk_out("ld0.e16", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("ld0.e17.ack", 32'(load_ack), 32'd0);
    chk_out("ld0.e17", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);
    chk_out("ld0.e18", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_out("ld0.e19", 1'b1, 1'b1, 1'b0, 1'b1);

    // Async reset mid-cycle
    reset = 1'b1;
    #2;
    chk_out("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst.active", 32'(active_half), 32'd7);
    chk("arst.ack", 32'(load_ack), 32'd0);
    reset = 1'b0;

    // Two loads (5 then 9) before the first wrap
    tick(1);
    load = 1'b1;
    half_period_in = 8'd5;
    tick(1);
    load = 1'b0;
    tick(1);
    load = 1'b1;
    half_period_in = 8'd9;
    tick(1);
    load = 1'b0;
    tick(2);
    chk("dbl.e6.ack", 32'(load_ack), 32'd0);
    chk("dbl.e6.active", 32'(active_half), 32'd7);
    tick(1);
    chk("dbl.e7.ack", 32'(load_ack), 32'd1);
    chk("dbl.e7.active", 32'(active_half), 32'd9);
    chk_out("dbl.e7", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 8; k <= 15; k++) begin
      tick(1);
      chk($sformatf("dbl.e%0d.ack", k), 32'(load_ack), 32'd0);
      chk($sformatf("dbl.e%0d.clk", k), 32'(new_clock), 32'd1);
    end
    tick(1);
    chk_out("dbl.e16", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(8);
    chk_out("dbl.e24", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_out("dbl.e25", 1'b1, 1'b1, 1'b0, 1'b0);

    // Resync at cnt=4 while high
    tick(4);
    chk_out("rs.e29", 1'b1, 1'b0, 1'b0, 1'b1);
    resync = 1'b1;
    tick(1);
    resync = 1'b0;
    chk_out("rs.e30", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(8);
    chk_out("rs.e38", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_out("rs.e39", 1'b1, 1'b1, 1'b0, 1'b0);

    // Enable low for 10 cycles, with a load applied while idle
    tick(2);
    enable = 1'b0;
    tick(2);
    chk_out("idle.e43", 1'b1, 1'b0, 1'b0, 1'b0);
    load = 1'b1;
    half_period_in = 8'd4;
    tick(1);
    load = 1'b0;
    chk("idle.e44.active", 32'(active_half), 32'd9);
    chk("idle.e44.ack", 32'(load_ack), 32'd0);
    chk_out("idle.e44", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("idle.e45.active", 32'(active_half), 32'd4);
    chk("idle.e45.ack", 32'(load_ack), 32'd1);
    for (int k = 46; k <= 51; k++) begin
      tick(1);
      chk($sformatf("idle.e%0d.ack", k), 32'(load_ack), 32'd0);
      chk_out($sformatf("idle.e%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    enable = 1'b1;
    tick(1);
    chk_out("resume.e52", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_out("resume.e53", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
